serial_deser: RTL and testbench

SERIAL_DESER -- requirements
Module: serial_deser

---
 rtl/serial_deser_pkg.sv | 11 +
 rtl/deser_out_buf.sv | 55 +++++
 rtl/serial_deser.sv | 112 +++++++++++
 tb/tb_serial_deser.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_deser_pkg.sv
// Shared types and constants for the serial deserializer.
package serial_deser_pkg;

  localparam int DESER_WIDTH_DEF = 8;

  typedef enum logic [0:0] {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } deser_state_t;

endpackage

// File: rtl/deser_out_buf.sv
// Single-entry output buffer with valid/ready handshake, sticky overflow and accepted-frame counter.
// Load visible 1 edge after i_frame_vld; a frame arriving while full and not accepted is dropped.
module deser_out_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_frame_vld,
  input  logic [DW-1:0] i_frame_dat,
  input  logic          i_rdy,
  output logic [DW-1:0] o_dat,
  output logic          o_vld,
  output logic          o_overflow,
  output logic [7:0]    o_frames
);

  logic [DW-1:0] r_dat;
  logic          r_vld;
  logic          r_overflow;
  logic [7:0]    r_frames;
  logic          w_accept;
  logic          w_load;

  assign w_accept = r_vld & i_rdy;
  // The buffer is free for a new frame when empty or being drained at this very edge.
  assign w_load   = i_frame_vld & (~r_vld | i_rdy);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dat      <= '0;
      r_vld      <= 1'b0;
      r_overflow <= 1'b0;
      r_frames   <= 8'd0;
    end else begin
      if (w_load) begin
        r_dat <= i_frame_dat;
        r_vld <= 1'b1;
      end else if (w_accept) begin
        r_vld <= 1'b0;
      end
      if (i_frame_vld && !w_load) begin
        r_overflow <= 1'b1;
      end
      if (w_accept) begin
        r_frames <= r_frames + 8'd1;
      end
    end
  end

  assign o_dat      = r_dat;
  assign o_vld      = r_vld;
  assign o_overflow = r_overflow;
  assign o_frames   = r_frames;

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel frame collector, first bit lands in word[0]; word_valid 1 edge after last bit.
// Optional even-parity bit per frame under SERIAL_DESER_PARITY_EN; frames are dropped when the output is held.
module serial_deser
  import serial_deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  output logic [7:0]       frames
`ifdef SERIAL_DESER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = $clog2(WIDTH);
`ifdef SERIAL_DESER_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  deser_state_t   r_state;
  deser_state_t   w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CW-1:0]  r_bitcnt;
  logic [CW-1:0]  w_bitcnt_nxt;
  logic           w_frame_vld;
  logic [DW-1:0]  w_frame_dat;
  logic [DW-1:0]  w_buf_dat;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_DATA;
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_frame_vld  = 1'b0;
    w_frame_dat  = '0;
    case (r_state)
      S_DATA: begin
        if (in_valid) begin
          w_shift_nxt[r_bitcnt] = in;
          if (r_bitcnt == CW'(WIDTH - 1)) begin
            w_bitcnt_nxt = '0;
`ifdef SERIAL_DESER_PARITY_EN
            w_state_nxt  = S_PAR;
`else
            // Completed word includes the bit being sampled at this edge.
            w_frame_vld  = 1'b1;
            w_frame_dat  = w_shift_nxt;
`endif
          end else begin
            w_bitcnt_nxt = r_bitcnt + CW'(1);
          end
        end
      end
`ifdef SERIAL_DESER_PARITY_EN
      S_PAR: begin
        if (in_valid) begin
          // Even parity: XOR over data and parity bit is 1 on error.
          w_frame_vld = 1'b1;
          w_frame_dat = {(^r_shift) ^ in, r_shift};
          w_state_nxt = S_DATA;
        end
      end
`endif
      default: begin
        w_state_nxt  = S_DATA;
        w_bitcnt_nxt = '0;
      end
    endcase
  end

  deser_out_buf #(
    .DW (DW)
  ) u_out_buf (
    .clk         (clk),
    .reset       (reset),
    .i_frame_vld (w_frame_vld),
    .i_frame_dat (w_frame_dat),
    .i_rdy       (word_ready),
    .o_dat       (w_buf_dat),
    .o_vld       (word_valid),
    .o_overflow  (overflow),
    .o_frames    (frames)
  );

  assign word = w_buf_dat[WIDTH-1:0];
`ifdef SERIAL_DESER_PARITY_EN
  assign parity_err = w_buf_dat[WIDTH];
`endif

endmodule

// File: tb/tb_serial_deser.sv
// Directed table-driven bench for serial_deser (WIDTH=8); parity cases under SERIAL_DESER_PARITY_EN.
module tb_serial_deser;

  logic       clk = 1'b0;
  logic       reset;
  logic       in;
  logic       in_valid;
  logic [7:0] word;
  logic       word_valid;
  logic       word_ready;
  logic       overflow;
  logic [7:0] frames;
`ifdef SERIAL_DESER_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_deser #(
    .WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .in_valid   (in_valid),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .frames     (frames)
`ifdef SERIAL_DESER_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  // seq is written in send order: seq[7] goes out first.
  typedef struct {
    logic [7:0] seq;
    bit         gap;
    logic [7:0] exp_word;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    in       = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] seq, input bit gap);
    for (int i = 7; i >= 0; i--) begin
      send_bit(seq[i]);
      if (gap && i != 0) idle(1);
    end
`ifdef SERIAL_DESER_PARITY_EN
    send_bit(^seq);
`endif
  endtask

  task automatic send_lsb(input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SERIAL_DESER_PARITY_EN
    send_bit(^d);
`endif
  endtask

  initial begin
    tbl[0] = '{seq: 8'b10110001, gap: 1'b0, exp_word: 8'h8D};
    tbl[1] = '{seq: 8'b11110000, gap: 1'b1, exp_word: 8'h0F};
    tbl[2] = '{seq: 8'b00000001, gap: 1'b1, exp_word: 8'h80};
    tbl[3] = '{seq: 8'b11000000, gap: 1'b0, exp_word: 8'h03};
    tbl[4] = '{seq: 8'b01100100, gap: 1'b0, exp_word: 8'h26};

    reset      = 1'b1;
    in         = 1'b0;
    in_valid   = 1'b0;
    word_ready = 1'b1;
    #1;
    idle(1);
    reset = 1'b0;
    chk("rst_word", 32'(word), 32'h00);
    chk("rst_vld", 32'(word_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_frames", 32'(frames), 32'd0);

    for (int k = 0; k < 5; k++) begin
      send_seq(tbl[k].seq, tbl[k].gap);
      chk($sformatf("tbl%0d_vld", k), 32'(word_valid), 32'd1);
      chk($sformatf("tbl%0d_word", k), 32'(word), 32'(tbl[k].exp_word));
      chk($sformatf("tbl%0d_frames_pre", k), 32'(frames), 32'(k));
      idle(1);
      chk($sformatf("tbl%0d_vld_drop", k), 32'(word_valid), 32'd0);
      chk($sformatf("tbl%0d_frames", k), 32'(frames), 32'(k + 1));
    end

    // Backpressure: second frame is dropped, first held.
    word_ready = 1'b0;
    send_seq(8'b10100101, 1'b0);
    chk("bp_first_word", 32'(word), 32'hA5);
    chk("bp_first_ovf", 32'(overflow), 32'd0);
    send_seq(8'b00111100, 1'b0);
    chk("bp_word_held", 32'(word), 32'hA5);
    chk("bp_vld_held", 32'(word_valid), 32'd1);
    chk("bp_ovf", 32'(overflow), 32'd1);
    chk("bp_frames_pre", 32'(frames), 32'd5);
    word_ready = 1'b1;
    idle(1);
    chk("bp_frames", 32'(frames), 32'd6);
    chk("bp_vld_drop", 32'(word_valid), 32'd0);
    chk("bp_ovf_sticky", 32'(overflow), 32'd1);

    // Reset after 5 bits discards the partial frame.
    repeat (5) send_bit(1'b1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("mid_rst_frames", 32'(frames), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_vld", 32'(word_valid), 32'd0);
    chk("mid_rst_word", 32'(word), 32'h00);
    repeat (3) send_bit(1'b1);
    chk("mid_rst_no_early", 32'(word_valid), 32'd0);
    repeat (5) send_bit(1'b1);
`ifdef SERIAL_DESER_PARITY_EN
    send_bit(1'b0);
`endif
    chk("mid_rst_word_ff", 32'(word), 32'hFF);
    chk("mid_rst_vld_ff", 32'(word_valid), 32'd1);
    idle(1);
    chk("mid_rst_frames_1", 32'(frames), 32'd1);

    // 255 more back-to-back frames wrap the counter from 1 to 0.
    for (int k = 0; k < 255; k++) send_lsb(8'(k));
    chk("wrap_last_word", 32'(word), 32'd254);
    idle(1);
    chk("wrap_frames", 32'(frames), 32'd0);
    chk("wrap_ovf", 32'(overflow), 32'd0);

    // Accept and completion at the same edge: buffer reloads, valid stays high.
    word_ready = 1'b0;
    send_lsb(8'h12);
    chk("sim_first_word", 32'(word), 32'h12);
    chk("sim_first_vld", 32'(word_valid), 32'd1);
    for (int i = 0; i < 7; i++) send_bit(1'(8'h34 >> i));
`ifdef SERIAL_DESER_PARITY_EN
    send_bit(1'b0);
    word_ready = 1'b1;
    send_bit(1'b1);
`else
    word_ready = 1'b1;
    send_bit(1'b0);
`endif
    chk("sim_vld", 32'(word_valid), 32'd1);
    chk("sim_word", 32'(word), 32'h34);
    chk("sim_frames", 32'(frames), 32'd1);
    chk("sim_ovf", 32'(overflow), 32'd0);
    idle(1);
    chk("sim_vld_drop", 32'(word_valid), 32'd0);
    chk("sim_frames_2", 32'(frames), 32'd2);

`ifdef SERIAL_DESER_PARITY_EN
    for (int i = 0; i < 8; i++) send_bit(1'(8'h8D >> i));
    send_bit(1'b0);
    chk("par_ok_word", 32'(word), 32'h8D);
    chk("par_ok_err", 32'(parity_err), 32'd0);
    idle(1);
    for (int i = 0; i < 8; i++) send_bit(1'(8'h8D >> i));
    send_bit(1'b1);
    chk("par_bad_word", 32'(word), 32'h8D);
    chk("par_bad_err", 32'(parity_err), 32'd1);
    idle(1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
